// File: rtl/weight_buf_pkg.sv
// -----------------------------------------------------------------------------
// weight_buf_pkg
// Shared definitions for the weight bank buffer:
//   - swap_state_t : swap FSM state encoding (also exported as a debug port)
//   - DEFAULT_*    : default bank geometry
//   - clog2_min1   : clog2 clamped to at least 1 bit, for counter/index widths
// -----------------------------------------------------------------------------
package weight_buf_pkg;

  localparam int DEFAULT_BANK_DEPTH = 1554;
  localparam int DEFAULT_NUM_BANKS  = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    SWAP  = 3'd2,
    COPY  = 3'd3,
    DONE  = 3'd4
  } swap_state_t;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// -----------------------------------------------------------------------------
// weight_bank_ram
// One weight buffer: DEPTH words, one write port and two independent
// synchronous read ports (1-cycle latency). Contents are not reset.
// Ports:
//   clk_i                         clock
//   we_i / waddr_i / wdata_i      write port
//   rd_en_i / rd_addr_i / rd_data_o  external (inference) read port
//   cp_en_i / cp_addr_i / cp_data_o  copy-back read port
// Read data registers hold their value when the enable is low.
// -----------------------------------------------------------------------------
module weight_bank_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  cp_en_i,
  input  logic [ADDR_WIDTH-1:0] cp_addr_i,
  output logic [DATA_WIDTH-1:0] cp_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] cp_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
    if (cp_en_i) begin
      cp_data_q <= mem_q[cp_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;
  assign cp_data_o = cp_data_q;

endmodule

// File: rtl/weight_bank_buffer.sv
// -----------------------------------------------------------------------------
// weight_bank_buffer
// NUM_BANKS double-buffered weight banks. Per bank, the active buffer is read
// by the inference core and the shadow buffer is written by the update engine.
// A swap request drains for DRAIN_CYCLES, flips the bank's active selection and
// optionally copies the new active buffer into the new shadow.
//
// Handshakes:
//   - Reads are never stalled: rd_en at cycle t yields rd_valid/rd_data at
//     t+RD_LATENCY. Out-of-range bank/address reads return 0 with rd_valid=1.
//   - A write is accepted when wr_en && wr_ready (wr_ready = !busy); writes to
//     an out-of-range bank/address are dropped.
//   - swap_req is a one-cycle request. It is accepted only in IDLE with a valid
//     swap_bank; otherwise swap_err pulses on the next cycle. swap_ack pulses
//     for the single DONE cycle.
// Ports:
//   clk, rst (sync, active-high)
//   rd_en/rd_bank/rd_addr -> rd_data/rd_valid
//   wr_en/wr_bank/wr_addr/wr_data, wr_ready
//   swap_req/swap_bank/swap_copy -> swap_ack/swap_err, busy
//   active_sel  per-bank active buffer index
//   dbg_state   swap FSM state
// -----------------------------------------------------------------------------
module weight_bank_buffer
  import weight_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int BANK_DEPTH   = DEFAULT_BANK_DEPTH,
  parameter int NUM_BANKS    = DEFAULT_NUM_BANKS,
  parameter int ADDR_WIDTH   = 11,
  parameter int BANK_WIDTH   = 2,
  parameter int RD_LATENCY   = 1,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [BANK_WIDTH-1:0] rd_bank,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [BANK_WIDTH-1:0] wr_bank,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  swap_req,
  input  logic [BANK_WIDTH-1:0] swap_bank,
  input  logic                  swap_copy,
  output logic                  swap_ack,
  output logic                  swap_err,
  output logic                  busy,
  output logic [NUM_BANKS-1:0]  active_sel,
  output swap_state_t           dbg_state
);

  localparam int RAM_AW   = clog2_min1(BANK_DEPTH);
  localparam int NUM_BUFS = 2 * NUM_BANKS;
  localparam int BUF_IW   = clog2_min1(NUM_BUFS);
  localparam int DRAIN_CW = clog2_min1(DRAIN_CYCLES);
  localparam int COPY_CW  = clog2_min1(BANK_DEPTH + 1);

  localparam logic [BANK_WIDTH:0] BANK_LIMIT = (BANK_WIDTH + 1)'(NUM_BANKS);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(BANK_DEPTH);
  localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(DRAIN_CYCLES - 1);
  localparam logic [COPY_CW-1:0]  COPY_LAST  = COPY_CW'(BANK_DEPTH);

  // ---------------------------------------------------------------------------
  // Swap FSM state
  // ---------------------------------------------------------------------------
  swap_state_t           state_q, state_d;
  logic [BANK_WIDTH-1:0] bank_q, bank_d;
  logic                  copy_q, copy_d;
  logic [DRAIN_CW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [COPY_CW-1:0]    copy_cnt_q, copy_cnt_d;
  logic [NUM_BANKS-1:0]  active_sel_q, active_sel_d;
  logic                  swap_err_q, swap_err_d;

  logic swap_bank_ok;
  assign swap_bank_ok = ({1'b0, swap_bank} < BANK_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bank_q       <= '0;
      copy_q       <= 1'b0;
      drain_cnt_q  <= '0;
      copy_cnt_q   <= '0;
      active_sel_q <= '0;
      swap_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      copy_q       <= copy_d;
      drain_cnt_q  <= drain_cnt_d;
      copy_cnt_q   <= copy_cnt_d;
      active_sel_q <= active_sel_d;
      swap_err_q   <= swap_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    copy_d       = copy_q;
    drain_cnt_d  = drain_cnt_q;
    copy_cnt_d   = copy_cnt_q;
    active_sel_d = active_sel_q;
    // Any request that is not accepted in IDLE is reported one cycle later.
    swap_err_d   = swap_req && ((state_q != IDLE) || !swap_bank_ok);

    unique case (state_q)
      IDLE: begin
        if (swap_req && swap_bank_ok) begin
          bank_d      = swap_bank;
          copy_d      = swap_copy;
          drain_cnt_d = '0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = SWAP;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_CW'(1);
        end
      end
      SWAP: begin
        // The flip registers at the end of this cycle, so a read issued in
        // the SWAP cycle still sees the pre-flip selection.
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (bank_q == BANK_WIDTH'(b)) begin
            active_sel_d[b] = ~active_sel_q[b];
          end
        end
        copy_cnt_d = '0;
        state_d    = copy_q ? COPY : DONE;
      end
      COPY: begin
        if (copy_cnt_q == COPY_LAST) begin
          state_d = DONE;
        end else begin
          copy_cnt_d = copy_cnt_q + COPY_CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign wr_ready   = ~busy;
  assign swap_ack   = (state_q == DONE);
  assign swap_err   = swap_err_q;
  assign active_sel = active_sel_q;
  assign dbg_state  = state_q;

  // ---------------------------------------------------------------------------
  // Copy-back pipeline: COPY cycle k reads word k (k < BANK_DEPTH) from the new
  // active buffer and writes word k-1 (k >= 1) into the new shadow.
  // ---------------------------------------------------------------------------
  logic               copy_rd_en;
  logic               copy_wr_en;
  logic [COPY_CW-1:0] copy_wr_idx;
  logic [RAM_AW-1:0]  copy_rd_addr;
  logic [RAM_AW-1:0]  copy_wr_addr;

  assign copy_rd_en   = (state_q == COPY) && (copy_cnt_q != COPY_LAST);
  assign copy_wr_en   = (state_q == COPY) && (copy_cnt_q != '0);
  assign copy_wr_idx  = copy_cnt_q - COPY_CW'(1);
  assign copy_rd_addr = copy_cnt_q[RAM_AW-1:0];
  assign copy_wr_addr = copy_wr_idx[RAM_AW-1:0];

  // ---------------------------------------------------------------------------
  // External access qualification
  // ---------------------------------------------------------------------------
  logic ext_we;
  logic rd_in_range;

  assign ext_we = wr_en && wr_ready &&
                  ({1'b0, wr_bank} < BANK_LIMIT) &&
                  ({1'b0, wr_addr} < ADDR_LIMIT);
  assign rd_in_range = ({1'b0, rd_bank} < BANK_LIMIT) &&
                       ({1'b0, rd_addr} < ADDR_LIMIT);

  // Buffer index is 2*bank + buffer, so bit 0 is the buffer select.
  logic [BUF_IW-1:0] rd_idx;
  logic [BUF_IW-1:0] cp_idx;

  always_comb begin
    rd_idx = '0;
    cp_idx = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_bank == BANK_WIDTH'(b)) begin
        rd_idx = BUF_IW'(2 * b) | BUF_IW'(active_sel_q[b]);
      end
      if (bank_q == BANK_WIDTH'(b)) begin
        cp_idx = BUF_IW'(2 * b) | BUF_IW'(active_sel_q[b]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Buffers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] buf_rd_data [NUM_BUFS];
  logic [DATA_WIDTH-1:0] buf_cp_data [NUM_BUFS];
  logic [DATA_WIDTH-1:0] copy_word;

  // Copy-read data is consumed one cycle after issue; active_sel is stable
  // throughout COPY, so cp_idx still points at the buffer that was read.
  always_comb begin
    copy_word = '0;
    for (int i = 0; i < NUM_BUFS; i++) begin
      if (cp_idx == BUF_IW'(i)) begin
        copy_word = buf_cp_data[i];
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar k = 0; k < 2; k++) begin : g_buf
      logic                  is_active;
      logic                  we;
      logic [RAM_AW-1:0]     waddr;
      logic [DATA_WIDTH-1:0] wdata;
      logic                  rd_hit;
      logic                  cp_hit;

      assign is_active = (active_sel_q[b] == 1'(k));
      // External writes only happen in IDLE and copy writes only in COPY,
      // so the two never contend for the write port.
      assign we    = !is_active &&
                     ((ext_we && (wr_bank == BANK_WIDTH'(b))) ||
                      (copy_wr_en && (bank_q == BANK_WIDTH'(b))));
      assign waddr = copy_wr_en ? copy_wr_addr : wr_addr[RAM_AW-1:0];
      assign wdata = copy_wr_en ? copy_word : wr_data;
      assign rd_hit = rd_en && rd_in_range && is_active &&
                      (rd_bank == BANK_WIDTH'(b));
      assign cp_hit = copy_rd_en && is_active && (bank_q == BANK_WIDTH'(b));

      weight_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BANK_DEPTH),
        .ADDR_WIDTH (RAM_AW)
      ) u_ram (
        .clk_i     (clk),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .rd_en_i   (rd_hit),
        .rd_addr_i (rd_addr[RAM_AW-1:0]),
        .rd_data_o (buf_rd_data[2*b+k]),
        .cp_en_i   (cp_hit),
        .cp_addr_i (copy_rd_addr),
        .cp_data_o (buf_cp_data[2*b+k])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path
  // ---------------------------------------------------------------------------
  logic              rd_v1_q;
  logic              rd_hit1_q;
  logic [BUF_IW-1:0] rd_idx1_q;
  logic [DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1_q   <= 1'b0;
      rd_hit1_q <= 1'b0;
      rd_idx1_q <= '0;
    end else begin
      rd_v1_q   <= rd_en;
      rd_hit1_q <= rd_en && rd_in_range;
      rd_idx1_q <= rd_idx;
    end
  end

  // Out-of-range reads (and idle cycles) return zero.
  always_comb begin
    rd_word = '0;
    if (rd_hit1_q) begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        if (rd_idx1_q == BUF_IW'(i)) begin
          rd_word = buf_rd_data[i];
        end
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_rd_lat2
    logic [DATA_WIDTH-1:0] rd_data2_q;
    logic                  rd_v2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data2_q <= '0;
        rd_v2_q    <= 1'b0;
      end else begin
        rd_data2_q <= rd_word;
        rd_v2_q    <= rd_v1_q;
      end
    end

    assign rd_data  = rd_data2_q;
    assign rd_valid = rd_v2_q;
  end else begin : g_rd_lat1
    assign rd_data  = rd_word;
    assign rd_valid = rd_v1_q;
  end

endmodule

// File: tb/tb_weight_bank_buffer.sv
module tb_weight_bank_buffer;
  import weight_buf_pkg::*;

  localparam int DW  = 16;
  localparam int BD  = 8;
  localparam int NB  = 3;
  localparam int AW  = 11;
  localparam int BW  = 2;
  localparam int RDL = 1;
  localparam int DC  = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          rd_en = 1'b0;
  logic [BW-1:0] rd_bank = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_en = 1'b0;
  logic [BW-1:0] wr_bank = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          swap_req = 1'b0;
  logic [BW-1:0] swap_bank = '0;
  logic          swap_copy = 1'b0;
  logic          swap_ack;
  logic          swap_err;
  logic          busy;
  logic [NB-1:0] active_sel;
  swap_state_t   dbg_state;

  weight_bank_buffer #(
    .DATA_WIDTH   (DW),
    .BANK_DEPTH   (BD),
    .NUM_BANKS    (NB),
    .ADDR_WIDTH   (AW),
    .BANK_WIDTH   (BW),
    .RD_LATENCY   (RDL),
    .DRAIN_CYCLES (DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .swap_req   (swap_req),
    .swap_bank  (swap_bank),
    .swap_copy  (swap_copy),
    .swap_ack   (swap_ack),
    .swap_err   (swap_err),
    .busy       (busy),
    .active_sel (active_sel),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_mem [NB][2][BD];
  logic [NB-1:0] m_sel = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input int b, input int a);
    if (b >= NB || a >= BD) return '0;
    return m_mem[b][m_sel[b]][a];
  endfunction

  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) check("rd_unexpected_qsize", 32'(exp_q.size()), 1);
      else check("rd_data", rd_data, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_read(input int b, input int a);
    rd_en   = 1'b1;
    rd_bank = BW'(b);
    rd_addr = AW'(a);
    exp_q.push_back(model_rd(b, a));
  endtask

  task automatic do_read(input int b, input int a);
    drive_read(b, a);
    tick();
    rd_en = 1'b0;
  endtask

  // Only called while the model is idle, so the write is expected to land.
  task automatic do_write(input int b, input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_bank = BW'(b);
    wr_addr = AW'(a);
    wr_data = d;
    if (b < NB && a < BD) m_mem[b][m_sel[b] ? 0 : 1][a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic model_swap(input int b, input logic cp);
    m_sel[b] = ~m_sel[b];
    if (cp) begin
      for (int a = 0; a < BD; a++) m_mem[b][m_sel[b] ? 0 : 1][a] = m_mem[b][m_sel[b]][a];
    end
  endtask

  task automatic swap_wait(input int b, input logic cp, input int exp_lat, input string tag);
    int n;
    swap_req  = 1'b1;
    swap_bank = BW'(b);
    swap_copy = cp;
    tick();
    swap_req  = 1'b0;
    swap_copy = 1'b0;
    check({tag, "_busy"}, busy, 1);
    n = 1;
    while (!swap_ack && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_ack_cycle"}, n, exp_lat);
    model_swap(b, cp);
    check({tag, "_sel"}, active_sel, m_sel);
    tick();
    check({tag, "_idle"}, busy, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int ack_k;

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_swap_ack", swap_ack, 0);
    check("rst_swap_err", swap_err, 0);
    check("rst_busy", busy, 0);
    check("rst_active_sel", active_sel, 0);
    check("rst_wr_ready", wr_ready, 1);
    rst = 1'b0;
    tick();

    // Bring every buffer to known contents: zeros become active,
    // a per-bank pattern stays in the shadow.
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < BD; a++) do_write(b, a, 16'h0000);
      swap_wait(b, 1'b0, DC + 2, "init");
      for (int a = 0; a < BD; a++) do_write(b, a, DW'(16'h0A00 + b * 16 + a));
    end

    // Shadow write invisible until swapped in
    do_write(1, 5, 16'h1234);
    do_read(1, 5);
    swap_wait(1, 1'b0, DC + 2, "swap1");
    do_read(1, 5);
    do_read(1, 4);

    // Swap with copy-back, then swap again: both buffers must match
    swap_wait(2, 1'b1, DC + BD + 3, "copy");
    for (int a = 0; a < BD; a++) do_read(2, a);
    swap_wait(2, 1'b0, DC + 2, "copy_back");
    for (int a = 0; a < BD; a++) do_read(2, a);

    // Request during DRAIN is rejected; write while busy is ignored
    swap_req  = 1'b1;
    swap_bank = BW'(0);
    tick();
    swap_req = 1'b0;
    tick();
    tick();
    swap_req  = 1'b1;
    swap_bank = BW'(1);
    wr_en     = 1'b1;
    wr_bank   = BW'(0);
    wr_addr   = AW'(1);
    wr_data   = 16'hDEAD;
    check("busy_wr_ready", wr_ready, 0);
    tick();
    swap_req = 1'b0;
    wr_en    = 1'b0;
    check("err_in_drain", swap_err, 1);
    check("err_in_drain_busy", busy, 1);
    tick();
    check("err_pulse_end", swap_err, 0);
    n = 5;
    while (!swap_ack && n < 200) begin
      tick();
      n++;
    end
    check("drain_ack_cycle", n, DC + 2);
    model_swap(0, 1'b0);
    check("no_second_flip", active_sel, m_sel);
    tick();
    check("drain_idle", busy, 0);
    do_read(0, 1);
    do_read(1, 1);

    // Invalid swap bank
    swap_req  = 1'b1;
    swap_bank = BW'(3);
    tick();
    swap_req = 1'b0;
    check("bad_bank_err", swap_err, 1);
    check("bad_bank_busy", busy, 0);
    tick();
    check("bad_bank_err_end", swap_err, 0);
    check("bad_bank_sel", active_sel, m_sel);

    // Back-to-back reads across the flip, with a same-cycle write + swap_req
    ack_k = -1;
    for (int k = 0; k < DC + 6; k++) begin
      if (k == 0) begin
        swap_req  = 1'b1;
        swap_bank = BW'(0);
        wr_en     = 1'b1;
        wr_bank   = BW'(0);
        wr_addr   = AW'(3);
        wr_data   = 16'hBEEF;
        m_mem[0][m_sel[0] ? 0 : 1][3] = 16'hBEEF;
      end
      if (k == DC + 2) m_sel[0] = ~m_sel[0];
      if (swap_ack) ack_k = k;
      drive_read(0, 3);
      tick();
      swap_req = 1'b0;
      wr_en    = 1'b0;
    end
    rd_en = 1'b0;
    check("b2b_ack_cycle", ack_k, DC + 2);
    check("b2b_sel", active_sel, m_sel);
    check("b2b_idle", busy, 0);

    // Out-of-range writes are dropped; out-of-range reads return zero
    do_write(1, BD, 16'hFFFF);
    do_write(1, 2047, 16'hFFFE);
    do_write(3, 2, 16'hFFFD);
    swap_wait(1, 1'b0, DC + 2, "oor");
    for (int a = 0; a < BD; a++) do_read(1, a);
    do_read(1, BD);
    do_read(3, 2);

    // Reset in the middle of COPY
    swap_req  = 1'b1;
    swap_bank = BW'(2);
    swap_copy = 1'b1;
    tick();
    swap_req  = 1'b0;
    swap_copy = 1'b0;
    n = 0;
    while (dbg_state != COPY && n < 100) begin
      tick();
      n++;
    end
    check("reach_copy", 32'(dbg_state), 32'(COPY));
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_sel", active_sel, 0);
    check("midrst_wr_ready", wr_ready, 1);
    m_sel = '0;
    // Bank 2 shadow contents are undefined now; rebuild both buffers.
    for (int a = 0; a < BD; a++) do_write(2, a, DW'(16'h5A00 + a));
    swap_wait(2, 1'b1, DC + BD + 3, "post_rst");
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < BD; a++) do_read(b, a);
    end

    tick();
    tick();
    tick();
    check("rd_queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
